io_1ton_chk: RTL and testbench
==============================

// Module: io_1ton_chk
// PURPOSE
//  Link test harness, N-way successor of the 1-to-2 harness: one 4-phase req/ack source, NUM_SNK checking sinks.
//  Source emits incrementing addr/dat; the fabric under test routes each message to one sink.
//  Each sink checks that it owns the address; adds per-sink accept counters, a message-count limit and optional data-sequence checking.
//  Sits beside the routing DUT in vl_tests benches; err/done outputs drive LEDs or bench asserts.
// PARAMETERS
//  NUM_SNK   2            number of sinks, 2..8
//  ASZ       ADDRESS_SIZE address width
//  DSZ       DATA_SIZE    data width
//  MIN_ADDR  1            first source address; also the wrap-back value
//  MAX_ADDR  1            last source address before wrap; requires MIN_ADDR<=MAX_ADDR
//  SEL_LSB   0            lsb of the sink selector field in addr; SEL_W=clog2(NUM_SNK), SEL_LSB+SEL_W<=ASZ
//  NUM_MSGS  0            messages to send; 0 = run forever
//  CNT_W     16           per-sink accept counter width
// PORTS
//  i_clk         in   1            main clock
//  i_rst_n       in   1            async active-low reset
//  i_run         in   1            source enable, level
//  o_addr        out  ASZ          source address
//  o_dat         out  DSZ          source data
//  o_req         out  1            source request
//  i_ack         in   1            source acknowledge
//  i_snk_addr    in   NUM_SNK*ASZ  sink k address at [k*ASZ +: ASZ]
//  i_snk_dat     in   NUM_SNK*DSZ  sink k data
//  i_snk_req     in   NUM_SNK      sink k request
//  o_snk_ack     out  NUM_SNK      sink k acknowledge
//  o_snk_ck_dat  out  NUM_SNK*DSZ  last datum accepted by sink k
//  o_snk_cnt     out  NUM_SNK*CNT_W  accepted-message count, sink k
//  o_err_addr    out  NUM_SNK      sticky: sink k saw a foreign address
//  o_err_seq     out  NUM_SNK      sticky: sink k sequence error
//  o_err_any     out  1            OR of all err bits
//  o_src_done    out  1            NUM_MSGS sent (0 if NUM_MSGS=0)
// BEHAVIOUR
//  Reset (async assert, sync release): o_addr=MIN_ADDR, o_dat=0, o_req=0, src state IDLE; all acks, ck_dat, cnt, err, done = 0.
//  Source FSM: IDLE -(i_run & !i_ack & !done)-> REQ; on entry o_req=1, o_addr=current address, o_dat=current data.
//   REQ -(i_ack)-> REL, o_req<=0. REL -(!i_ack)-> IDLE, sent-count++.
//   Address steps per message MIN..MAX, then wraps to MIN; dat +1 mod 2^DSZ; the first message after reset carries addr MIN_ADDR, dat 1.
//   i_run low only blocks IDLE->REQ; a handshake already in flight completes.
//   When sent-count reaches NUM_MSGS, o_src_done=1 and the FSM stays in IDLE until reset.
//  Sink k (all independent, identical): when i_snk_req[k] & !ack[k]:
//   if addr[SEL_LSB+:SEL_W]!=k: set o_err_addr[k]; no ack (link stalls; bench sees err).
//   else if a sequence check is enabled and fails: set o_err_seq[k]; no ack.
//   else: ck_dat<=dat, cnt++ (wraps at 2^CNT_W), ack<=1 next cycle (1-cycle latency).
//   !req & ack -> ack<=0. Req held while ack high: no re-accept.
//  Selector values >= NUM_SNK match no sink; every sink receiving one flags err_addr.
//  Errors are sticky until reset. Reset mid-handshake drops req/ack at once; the DUT must tolerate this.
// CONFIGURATION
//  IO_1TON_SEQ_CHK_EN defined: per-sink data check; d=(dat-ck_dat) mod 2^DSZ; error if d==0 or d[DSZ-1]==1.
//   Check skipped for the first accept after reset (cnt==0).
//  Not defined: o_err_seq tied 0; no compare logic.
// STRUCTURE
//  hglobal.v: ON/OFF/TRUE/FALSE, ADDRESS_SIZE, DATA_SIZE, and new src state encodings SRC_IDLE/SRC_REQ/SRC_REL.
//  Submodule io_snk_chk (one sink: params IDX, SEL_LSB, SEL_W, ASZ, DSZ, CNT_W); instantiated NUM_SNK times by a generate loop.
// TESTING
//  Loopback: route by selector, NUM_SNK=4, MIN=0, MAX=7, SEL_LSB=0, NUM_MSGS=16 -> each cnt=4, o_src_done=1, o_err_any=0.
//  Misroute addr 2 to sink 1 -> o_err_addr=4'b0010, ack[1] stays 0, o_req stays 1.
//  Stalling DUT: i_ack held 0 for 20 cycles -> o_req held 1, addr/dat stable, no counts change.
//  i_run dropped mid-REQ -> handshake finishes, no new req while i_run=0, resumes with next addr.
//  SEQ_CHK_EN: sink 0 gets dat 5 then 5 -> o_err_seq[0]=1; without macro: no err, cnt=2.
//  Async reset asserted mid-REL -> all outputs 0 within the reset cycle, o_addr=MIN_ADDR, restart clean.

Source files
------------

// File: rtl/io_1ton_chk_pkg.sv
// Shared constants, source state encodings and helpers for the io_1ton_chk link harness.
// The optional data-sequence check is enabled by defining IO_1TON_SEQ_CHK_EN.
package io_1ton_chk_pkg;

  localparam bit ON    = 1'b1;
  localparam bit OFF   = 1'b0;
  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;

  localparam int ADDRESS_SIZE = 8;
  localparam int DATA_SIZE    = 8;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_REQ  = 2'd1,
    SRC_REL  = 2'd2
  } src_state_e;

  // Width of the sink selector field; at least one bit even for two sinks.
  function automatic int sel_width(input int num_snk);
    return (num_snk <= 2) ? 1 : $clog2(num_snk);
  endfunction

endpackage

// File: rtl/io_1ton_chk_snk.sv
// One checking sink: accepts 4-phase messages addressed to selector IDX and records the last datum.
// With IO_1TON_SEQ_CHK_EN defined, successive data must strictly increase (mod 2^DSZ, half-range window).
module io_snk_chk
  import io_1ton_chk_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int SEL_LSB = 0,
  parameter int SEL_W   = 1,
  parameter int ASZ     = ADDRESS_SIZE,
  parameter int DSZ     = DATA_SIZE,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [ASZ-1:0]   i_addr,
  input  logic [DSZ-1:0]   i_dat,
  input  logic             i_req,
  output logic             o_ack,
  output logic [DSZ-1:0]   o_ck_dat,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err_addr,
  output logic             o_err_seq
);

  localparam logic [SEL_W-1:0] IDX_SEL = SEL_W'(IDX);

  logic             ack_d, ack_q;
  logic [DSZ-1:0]   ck_dat_d, ck_dat_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_addr_d, err_addr_q;
  logic             sel_hit;

  assign sel_hit = (i_addr[SEL_LSB +: SEL_W] == IDX_SEL);

`ifdef IO_1TON_SEQ_CHK_EN
  logic             err_seq_d, err_seq_q;
  logic [DSZ-1:0]   seq_diff;
  logic             seq_bad;

  // A repeat (diff 0) or a step backwards (diff in upper half) is a sequence error.
  assign seq_diff = i_dat - ck_dat_q;
  assign seq_bad  = (cnt_q != '0) && ((seq_diff == '0) || seq_diff[DSZ-1]);
`endif

  always_comb begin
    ack_d      = ack_q;
    ck_dat_d   = ck_dat_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;
`ifdef IO_1TON_SEQ_CHK_EN
    err_seq_d  = err_seq_q;
`endif
    if (i_req && !ack_q) begin
      // A rejected message is never acked, so the link stalls with the error visible.
      if (!sel_hit) begin
        err_addr_d = 1'b1;
      end
`ifdef IO_1TON_SEQ_CHK_EN
      else if (seq_bad) begin
        err_seq_d = 1'b1;
      end
`endif
      else begin
        ack_d    = 1'b1;
        ck_dat_d = i_dat;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end else if (!i_req && ack_q) begin
      ack_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q      <= 1'b0;
      ck_dat_q   <= '0;
      cnt_q      <= '0;
      err_addr_q <= 1'b0;
`ifdef IO_1TON_SEQ_CHK_EN
      err_seq_q  <= 1'b0;
`endif
    end else begin
      ack_q      <= ack_d;
      ck_dat_q   <= ck_dat_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
`ifdef IO_1TON_SEQ_CHK_EN
      err_seq_q  <= err_seq_d;
`endif
    end
  end

  assign o_ack      = ack_q;
  assign o_ck_dat   = ck_dat_q;
  assign o_cnt      = cnt_q;
  assign o_err_addr = err_addr_q;
`ifdef IO_1TON_SEQ_CHK_EN
  assign o_err_seq  = err_seq_q;
`else
  assign o_err_seq  = 1'b0;
`endif

endmodule

// File: rtl/io_1ton_chk.sv
// 1-to-N link harness: a 4-phase req/ack source with incrementing addr/dat and NUM_SNK checking sinks.
// Optional per-sink data-sequence check under IO_1TON_SEQ_CHK_EN.
// Handshake: o_req rises with stable addr/dat, stays high until i_ack, then falls; the next
// request waits for i_ack low. Sinks mirror this: ack rises one cycle after an accepted req
// and falls one cycle after req drops.
module io_1ton_chk
  import io_1ton_chk_pkg::*;
#(
  parameter int NUM_SNK  = 2,
  parameter int ASZ      = ADDRESS_SIZE,
  parameter int DSZ      = DATA_SIZE,
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 1,
  parameter int SEL_LSB  = 0,
  parameter int NUM_MSGS = 0,
  parameter int CNT_W    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_run,
  output logic [ASZ-1:0]           o_addr,
  output logic [DSZ-1:0]           o_dat,
  output logic                     o_req,
  input  logic                     i_ack,
  input  logic [NUM_SNK*ASZ-1:0]   i_snk_addr,
  input  logic [NUM_SNK*DSZ-1:0]   i_snk_dat,
  input  logic [NUM_SNK-1:0]       i_snk_req,
  output logic [NUM_SNK-1:0]       o_snk_ack,
  output logic [NUM_SNK*DSZ-1:0]   o_snk_ck_dat,
  output logic [NUM_SNK*CNT_W-1:0] o_snk_cnt,
  output logic [NUM_SNK-1:0]       o_err_addr,
  output logic [NUM_SNK-1:0]       o_err_seq,
  output logic                     o_err_any,
  output logic                     o_src_done,
  output logic [1:0]               o_src_state
);

  localparam int             SEL_W = sel_width(NUM_SNK);
  localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);
  localparam logic [31:0]    MSGS  = 32'(NUM_MSGS);

  src_state_e     state_d, state_q;
  logic           req_d, req_q;
  logic [ASZ-1:0] addr_d, addr_q;
  logic [DSZ-1:0] dat_d, dat_q;
  logic [ASZ-1:0] cur_addr_d, cur_addr_q;
  logic [DSZ-1:0] cur_dat_d, cur_dat_q;
  logic [31:0]    sent_d, sent_q;
  logic           done_d, done_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    cur_addr_d = cur_addr_q;
    cur_dat_d  = cur_dat_q;
    sent_d     = sent_q;
    done_d     = done_q;
    case (state_q)
      SRC_IDLE: begin
        if (i_run && !i_ack && !done_q) begin
          state_d = SRC_REQ;
          req_d   = 1'b1;
          addr_d  = cur_addr_q;
          dat_d   = cur_dat_q;
        end
      end
      SRC_REQ: begin
        if (i_ack) begin
          state_d = SRC_REL;
          req_d   = 1'b0;
        end
      end
      SRC_REL: begin
        // Message counts as sent only once the far side has released ack.
        if (!i_ack) begin
          state_d    = SRC_IDLE;
          sent_d     = sent_q + 32'd1;
          cur_addr_d = (cur_addr_q == MAX_A) ? MIN_A : cur_addr_q + ASZ'(1);
          cur_dat_d  = cur_dat_q + DSZ'(1);
          if ((MSGS != 32'd0) && (sent_q + 32'd1 == MSGS)) begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SRC_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SRC_IDLE;
      req_q      <= 1'b0;
      addr_q     <= MIN_A;
      dat_q      <= '0;
      cur_addr_q <= MIN_A;
      cur_dat_q  <= DSZ'(1);
      sent_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      cur_addr_q <= cur_addr_d;
      cur_dat_q  <= cur_dat_d;
      sent_q     <= sent_d;
      done_q     <= done_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_dat       = dat_q;
  assign o_req       = req_q;
  assign o_src_done  = done_q;
  assign o_src_state = state_q;

  for (genvar k = 0; k < NUM_SNK; k++) begin : g_snk
    io_snk_chk #(
      .IDX     (k),
      .SEL_LSB (SEL_LSB),
      .SEL_W   (SEL_W),
      .ASZ     (ASZ),
      .DSZ     (DSZ),
      .CNT_W   (CNT_W)
    ) u_snk (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_addr     (i_snk_addr[k*ASZ +: ASZ]),
      .i_dat      (i_snk_dat[k*DSZ +: DSZ]),
      .i_req      (i_snk_req[k]),
      .o_ack      (o_snk_ack[k]),
      .o_ck_dat   (o_snk_ck_dat[k*DSZ +: DSZ]),
      .o_cnt      (o_snk_cnt[k*CNT_W +: CNT_W]),
      .o_err_addr (o_err_addr[k]),
      .o_err_seq  (o_err_seq[k])
    );
  end

  assign o_err_any = (|o_err_addr) | (|o_err_seq);

endmodule

// File: tb/tb_io_1ton_chk.sv
// Bench for io_1ton_chk: the bench acts as the routing fabric between source and sinks.
// Build with or without IO_1TON_SEQ_CHK_EN; the sequence scenario adapts its expectations.
module tb_io_1ton_chk;
  import io_1ton_chk_pkg::*;

  localparam int NUM_SNK  = 4;
  localparam int ASZ      = 8;
  localparam int DSZ      = 8;
  localparam int MIN_ADDR = 0;
  localparam int MAX_ADDR = 7;
  localparam int SEL_LSB  = 0;
  localparam int NUM_MSGS = 16;
  localparam int CNT_W    = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     run = 1'b0;
  logic                     ack = 1'b0;
  logic [ASZ-1:0]           addr;
  logic [DSZ-1:0]           dat;
  logic                     req;
  logic [NUM_SNK*ASZ-1:0]   snk_addr = '0;
  logic [NUM_SNK*DSZ-1:0]   snk_dat = '0;
  logic [NUM_SNK-1:0]       snk_req = '0;
  logic [NUM_SNK-1:0]       snk_ack;
  logic [NUM_SNK*DSZ-1:0]   snk_ck_dat;
  logic [NUM_SNK*CNT_W-1:0] snk_cnt;
  logic [NUM_SNK-1:0]       err_addr;
  logic [NUM_SNK-1:0]       err_seq;
  logic                     err_any;
  logic                     src_done;
  logic [1:0]               src_state;

  io_1ton_chk #(
    .NUM_SNK(NUM_SNK), .ASZ(ASZ), .DSZ(DSZ), .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR),
    .SEL_LSB(SEL_LSB), .NUM_MSGS(NUM_MSGS), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
    .o_addr(addr), .o_dat(dat), .o_req(req), .i_ack(ack),
    .i_snk_addr(snk_addr), .i_snk_dat(snk_dat), .i_snk_req(snk_req),
    .o_snk_ack(snk_ack), .o_snk_ck_dat(snk_ck_dat), .o_snk_cnt(snk_cnt),
    .o_err_addr(err_addr), .o_err_seq(err_seq), .o_err_any(err_any),
    .o_src_done(src_done), .o_src_state(src_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboards: source {addr,dat}; sink {ck_dat,cnt}
  logic [ASZ+DSZ-1:0]   src_q[$];
  logic [DSZ+CNT_W-1:0] snk_q[$];
  logic [ASZ-1:0]       mdl_addr;
  logic [DSZ-1:0]       mdl_dat;
  logic [CNT_W-1:0]     exp_cnt[NUM_SNK];

  task automatic model_reset();
    src_q.delete();
    snk_q.delete();
    mdl_addr = ASZ'(MIN_ADDR);
    mdl_dat  = DSZ'(1);
    for (int k = 0; k < NUM_SNK; k++) exp_cnt[k] = '0;
    src_q.push_back({mdl_addr, mdl_dat});
  endtask

  task automatic model_next();
    mdl_addr = (mdl_addr == ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : mdl_addr + ASZ'(1);
    mdl_dat  = mdl_dat + DSZ'(1);
    src_q.push_back({mdl_addr, mdl_dat});
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    run     = 1'b0;
    ack     = 1'b0;
    snk_req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_req: o_req=%b required 1 within 50 cycles", req);
    end
  endtask

  task automatic check_src_msg();
    logic [ASZ+DSZ-1:0] exp;
    checks++;
    if (src_q.size() == 0) begin
      errors++;
      $display("FAIL src_msg: got addr=%0d dat=%0d, no entry expected", addr, dat);
    end else begin
      exp = src_q.pop_front();
      if ({addr, dat} !== exp)
        begin errors++; $display("FAIL src_msg: addr=%0d dat=%0d required addr=%0d dat=%0d",
                                 addr, dat, exp[ASZ+DSZ-1:DSZ], exp[DSZ-1:0]); end
    end
  endtask

  task automatic deliver(input int k, input logic [ASZ-1:0] a, input logic [DSZ-1:0] d,
                         input bit expect_ok);
    snk_addr[k*ASZ +: ASZ] = a;
    snk_dat[k*DSZ +: DSZ]  = d;
    snk_req[k]             = 1'b1;
    if (expect_ok) begin
      exp_cnt[k] = exp_cnt[k] + CNT_W'(1);
      snk_q.push_back({d, exp_cnt[k]});
    end
  endtask

  task automatic finish_snk(input int k, output bit ok);
    logic [DSZ+CNT_W-1:0] exp;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (snk_ack[k] === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL snk_ack[%0d]: ack=%b required 1 within 20 cycles", k, snk_ack[k]);
      snk_req[k] = 1'b0;
      return;
    end
    exp = snk_q.pop_front();
    if ({snk_ck_dat[k*DSZ +: DSZ], snk_cnt[k*CNT_W +: CNT_W]} !== exp) begin
      errors++;
      $display("FAIL snk_accept[%0d]: ck_dat=%0d cnt=%0d required ck_dat=%0d cnt=%0d", k,
               snk_ck_dat[k*DSZ +: DSZ], snk_cnt[k*CNT_W +: CNT_W], exp[DSZ+CNT_W-1:CNT_W],
               exp[CNT_W-1:0]);
    end
    snk_req[k] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (snk_ack[k] === 1'b0) break;
      @(negedge clk);
    end
    checks++;
    if (snk_ack[k] !== 1'b0) begin
      errors++; ok = 1'b0;
      $display("FAIL snk_ack_drop[%0d]: ack=%b required 0", k, snk_ack[k]);
    end
  endtask

  task automatic src_release();
    ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req === 1'b0) break;
      @(negedge clk);
    end
    checks++;
    if (req !== 1'b0) begin
      errors++; $display("FAIL src_req_drop: o_req=%b required 0", req);
    end
  endtask

  // one full message: source -> fabric -> sink, routed by selector unless k_force >= 0
  task automatic relay(input int k_force);
    bit ok;
    int k;
    wait_req(ok);
    if (!ok) return;
    check_src_msg();
    k = (k_force >= 0) ? k_force : int'(addr[SEL_LSB +: 2]);
    deliver(k, addr, dat, 1'b1);
    finish_snk(k, ok);
    if (!ok) return;
    src_release();
    ack = 1'b0;
    model_next();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req, addr, dat, snk_ack, snk_cnt, err_addr, err_seq, err_any, src_done} !== '0 ||
        src_state !== 2'(SRC_IDLE)) begin
      errors++;
      $display("FAIL reset_vals: req=%b addr=%0d dat=%0d ack=%b err=%b/%b done=%b st=%0d required all 0",
               req, addr, dat, snk_ack, err_addr, err_seq, src_done, src_state);
    end
    apply_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (req !== 1'b0 || src_state !== 2'(SRC_IDLE) || snk_ck_dat !== '0) begin
      errors++;
      $display("FAIL idle_no_run: req=%b st=%0d ck=%h required req=0 st=0 ck=0", req, src_state, snk_ck_dat);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [ASZ-1:0] a0;
    logic [DSZ-1:0] d0;
    int bad = 0;
    run = 1'b1;
    wait_req(ok);
    if (!ok) return;
    a0 = addr;
    d0 = dat;
    repeat (20) begin
      @(negedge clk);
      if (req !== 1'b1 || addr !== a0 || dat !== d0 || snk_cnt !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d bad cycles, last req=%b addr=%0d dat=%0d required req=1 addr=%0d dat=%0d",
               bad, req, addr, dat, a0, d0);
    end
    relay(-1);
  endtask

  task automatic test_run_drop();
    bit ok;
    int bad = 0;
    wait_req(ok);
    if (!ok) return;
    run = 1'b0;
    relay(-1);
    repeat (10) begin
      @(negedge clk);
      if (req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL run_low_block: o_req high in %0d cycles required 0", bad);
    end
    run = 1'b1;
    relay(-1);
  endtask

  task automatic test_loopback();
    int bad = 0;
    for (int m = 3; m < NUM_MSGS; m++) relay(-1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < NUM_SNK; k++) begin
      checks++;
      if (snk_cnt[k*CNT_W +: CNT_W] !== CNT_W'(4)) begin
        errors++;
        $display("FAIL loop_cnt[%0d]: cnt=%0d required 4", k, snk_cnt[k*CNT_W +: CNT_W]);
      end
    end
    checks++;
    if (src_done !== 1'b1 || err_any !== 1'b0) begin
      errors++; $display("FAIL loop_done: done=%b err_any=%b required done=1 err_any=0", src_done, err_any);
    end
    repeat (5) begin
      @(negedge clk);
      if (req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL done_no_req: o_req high %0d cycles after done required 0", bad);
    end
  endtask

  task automatic test_misroute();
    bit ok;
    apply_reset();
    run = 1'b1;
    relay(-1);
    relay(-1);
    wait_req(ok);
    if (!ok) return;
    check_src_msg();
    deliver(1, addr, dat, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (err_addr !== 4'b0010 || snk_ack[1] !== 1'b0 || req !== 1'b1 || err_any !== 1'b1 ||
        snk_cnt[1*CNT_W +: CNT_W] !== CNT_W'(1)) begin
      errors++;
      $display("FAIL misroute: err_addr=%b ack1=%b req=%b any=%b cnt1=%0d required 0010 0 1 1 1",
               err_addr, snk_ack[1], req, err_any, snk_cnt[1*CNT_W +: CNT_W]);
    end
    snk_req = '0;
  endtask

  task automatic test_seq();
    bit ok;
    apply_reset();
    deliver(0, 8'd0, 8'd5, 1'b1);
    finish_snk(0, ok);
`ifdef IO_1TON_SEQ_CHK_EN
    deliver(0, 8'd4, 8'd5, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (err_seq !== 4'b0001 || snk_ack[0] !== 1'b0 || snk_cnt[CNT_W-1:0] !== CNT_W'(1) ||
        err_any !== 1'b1) begin
      errors++;
      $display("FAIL seq_repeat: err_seq=%b ack0=%b cnt0=%0d any=%b required 0001 0 1 1",
               err_seq, snk_ack[0], snk_cnt[CNT_W-1:0], err_any);
    end
    snk_req = '0;
`else
    deliver(0, 8'd4, 8'd5, 1'b1);
    finish_snk(0, ok);
    checks++;
    if (err_seq !== 4'b0000 || err_any !== 1'b0 || snk_cnt[CNT_W-1:0] !== CNT_W'(2)) begin
      errors++;
      $display("FAIL seq_off: err_seq=%b any=%b cnt0=%0d required 0000 0 2",
               err_seq, err_any, snk_cnt[CNT_W-1:0]);
    end
`endif
  endtask

  task automatic test_reset_mid_rel();
    bit ok;
    apply_reset();
    run = 1'b1;
    wait_req(ok);
    if (!ok) return;
    check_src_msg();
    deliver(0, addr, dat, 1'b1);
    finish_snk(0, ok);
    src_release();
    checks++;
    if (src_state !== 2'(SRC_REL)) begin
      errors++; $display("FAIL rel_state: state=%0d required %0d", src_state, SRC_REL);
    end
    #2;
    rst_n   = 1'b0;
    ack     = 1'b0;
    snk_req = '0;
    #1;
    checks++;
    if ({req, dat, snk_ack, snk_cnt, snk_ck_dat, err_addr, err_seq, src_done} !== '0 ||
        addr !== ASZ'(MIN_ADDR) || src_state !== 2'(SRC_IDLE)) begin
      errors++;
      $display("FAIL reset_mid_rel: req=%b addr=%0d dat=%0d ack=%b cnt=%h st=%0d required 0 %0d 0 0 0 0",
               req, addr, dat, snk_ack, snk_cnt, src_state, MIN_ADDR);
    end
    apply_reset();
    run = 1'b1;
    relay(-1);
    relay(-1);
    checks++;
    if (err_any !== 1'b0) begin
      errors++; $display("FAIL restart_clean: err_any=%b required 0", err_any);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stall();
    test_run_drop();
    test_loopback();
    test_misroute();
    test_seq();
    test_reset_mid_rel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
